// File: rtl/vga_pkg.sv
// Shared 800x600@60 raster constants and decode helpers used by the timing
// generator and every downstream drawing stage.
package vga_pkg;

  localparam int COUNT_W   = 11;
  localparam int MAX_TOTAL = 2 ** COUNT_W;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b1;

  // Inclusive window test on a counter value.
  function automatic logic in_window(input logic [COUNT_W-1:0] value,
                                     input logic [COUNT_W-1:0] lo,
                                     input logic [COUNT_W-1:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously with rst_n, releases two clock
// edges after rst_n rises so downstream flops leave reset cleanly.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_reg[1];

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator; counters and all decoded flags are
// registered together from next-state values so they always describe one pixel.
module vga_timing #(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic        pclk,
  input  logic        rst_n,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        frame_start
);

  import vga_pkg::*;

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (LINE_TOTAL > MAX_TOTAL || FRAME_LINES > MAX_TOTAL) begin : g_width_check
    $error("vga_timing: raster totals do not fit the 11-bit counters");
  end

  localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(LINE_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_BLANK_LO = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_LO      = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] HS_HI      = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(FRAME_LINES - 1);
  localparam logic [COUNT_W-1:0] V_BLANK_LO = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] VS_LO      = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] VS_HI      = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic                rst_sync_n;
  logic [COUNT_W-1:0]  hcount_next;
  logic [COUNT_W-1:0]  vcount_next;

  reset_sync u_reset_sync (
    .clk        (pclk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  // vcount only moves on the line wrap, so vsync/vblnk change with hcount=0.
  always_comb begin
    hcount_next = hcount_out + 11'd1;
    vcount_next = vcount_out;
    if (hcount_out == H_LAST) begin
      hcount_next = '0;
      vcount_next = (vcount_out == V_LAST) ? '0 : vcount_out + 11'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      hsync_out   <= ~SYNC_POL;
      vsync_out   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= hcount_next;
      vcount_out  <= vcount_next;
      hblnk_out   <= hcount_next >= H_BLANK_LO;
      vblnk_out   <= vcount_next >= V_BLANK_LO;
      hsync_out   <= in_window(hcount_next, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync_out   <= in_window(vcount_next, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      frame_start <= (hcount_next == '0) && (vcount_next == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for line timing, shrunken instances
// (both sync polarities) for frame-level behaviour within a short run.
module tb_vga_timing;

  logic pclk;
  logic rst_n;

  logic [10:0] b_vc, b_hc, s_vc, s_hc, n_vc, n_hc;
  logic b_vs, b_vb, b_hs, b_hb, b_fs;
  logic s_vs, s_vb, s_hs, s_hb, s_fs;
  logic n_vs, n_vb, n_hs, n_hb, n_fs;

  int n_cmp  = 0;
  int n_fail = 0;
  int m      = 0;
  int gap;

  vga_timing dut (
    .pclk(pclk), .rst_n(rst_n),
    .vcount_out(b_vc), .vsync_out(b_vs), .vblnk_out(b_vb),
    .hcount_out(b_hc), .hsync_out(b_hs), .hblnk_out(b_hb),
    .frame_start(b_fs)
  );

  // Small raster: H 8+2+3+2=15 (hsync 10..12), V 6+1+2+3=12 (vsync 7..8).
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) dut_s (
    .pclk(pclk), .rst_n(rst_n),
    .vcount_out(s_vc), .vsync_out(s_vs), .vblnk_out(s_vb),
    .hcount_out(s_hc), .hsync_out(s_hs), .hblnk_out(s_hb),
    .frame_start(s_fs)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) dut_n (
    .pclk(pclk), .rst_n(rst_n),
    .vcount_out(n_vc), .vsync_out(n_vs), .vblnk_out(n_vb),
    .hcount_out(n_hc), .hsync_out(n_hs), .hblnk_out(n_hb),
    .frame_start(n_fs)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the small rasters to absolute position index target after release.
  task automatic adv(input int target);
    tick(target - m);
    m = target;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(10);
    chk_cnt("rst_hcount", b_hc, 11'd0);
    chk_cnt("rst_vcount", b_vc, 11'd0);
    chk_bit("rst_hsync", b_hs, 1'b0);
    chk_bit("rst_vsync", b_vs, 1'b0);
    chk_bit("rst_hblnk", b_hb, 1'b0);
    chk_bit("rst_vblnk", b_vb, 1'b0);
    chk_bit("rst_fs", b_fs, 1'b0);
    chk_bit("rst_neg_hsync", n_hs, 1'b1);
    chk_bit("rst_neg_vsync", n_vs, 1'b1);

    // Release between edges; two synchronizer edges pass before counting.
    @(negedge pclk);
    rst_n = 1'b1;
    tick(1);
    chk_cnt("sync_edge1", b_hc, 11'd0);
    tick(1);
    chk_cnt("sync_edge2", b_hc, 11'd0);
    tick(1);
    chk_cnt("count_1", b_hc, 11'd1);
    chk_bit("no_fs_frame0", b_fs, 1'b0);
    tick(1);
    chk_cnt("count_2", b_hc, 11'd2);

    tick(797);
    chk_cnt("h799", b_hc, 11'd799);
    chk_bit("h799_hblnk", b_hb, 1'b0);
    tick(1);
    chk_bit("h800_hblnk", b_hb, 1'b1);
    chk_bit("h800_hsync", b_hs, 1'b0);
    tick(39);
    chk_cnt("h839", b_hc, 11'd839);
    chk_bit("h839_hsync", b_hs, 1'b0);
    tick(1);
    chk_bit("h840_hsync", b_hs, 1'b1);
    tick(127);
    chk_cnt("h967", b_hc, 11'd967);
    chk_bit("h967_hsync", b_hs, 1'b1);
    tick(1);
    chk_bit("h968_hsync", b_hs, 1'b0);
    tick(87);
    chk_cnt("h1055", b_hc, 11'd1055);
    chk_bit("h1055_hblnk", b_hb, 1'b1);
    chk_cnt("h1055_vcount", b_vc, 11'd0);
    tick(1);
    chk_cnt("wrap_hcount", b_hc, 11'd0);
    chk_cnt("wrap_vcount", b_vc, 11'd1);
    chk_bit("wrap_hblnk", b_hb, 1'b0);
    chk_bit("wrap_vsync", b_vs, 1'b0);

    // Asynchronous mid-line reset, asserted away from any clock edge.
    tick(500);
    chk_cnt("pre_rst_hcount", b_hc, 11'd500);
    #3;
    rst_n = 1'b0;
    #1;
    chk_cnt("async_hcount", b_hc, 11'd0);
    chk_cnt("async_vcount", b_vc, 11'd0);
    chk_bit("async_hblnk", b_hb, 1'b0);
    chk_cnt("async_s_hcount", s_hc, 11'd0);
    tick(3);
    chk_bit("async_fs", b_fs, 1'b0);
    @(negedge pclk);
    rst_n = 1'b1;
    tick(2);
    chk_cnt("restart_hcount", b_hc, 11'd0);
    chk_bit("restart_fs", s_fs, 1'b0);
    m = 0;

    adv(1);
    chk_cnt("s_m1_hcount", s_hc, 11'd1);
    chk_bit("s_m1_fs", s_fs, 1'b0);
    chk_cnt("b_m1_hcount", b_hc, 11'd1);
    adv(7);
    chk_bit("s_h7_hblnk", s_hb, 1'b0);
    adv(8);
    chk_bit("s_h8_hblnk", s_hb, 1'b1);
    adv(9);
    chk_bit("s_h9_hsync", s_hs, 1'b0);
    chk_bit("n_h9_hsync", n_hs, 1'b1);
    adv(10);
    chk_bit("s_h10_hsync", s_hs, 1'b1);
    chk_bit("n_h10_hsync", n_hs, 1'b0);
    adv(12);
    chk_bit("s_h12_hsync", s_hs, 1'b1);
    adv(13);
    chk_bit("s_h13_hsync", s_hs, 1'b0);
    adv(15);
    chk_cnt("s_line1_hcount", s_hc, 11'd0);
    chk_cnt("s_line1_vcount", s_vc, 11'd1);
    chk_cnt("n_line1_vcount", n_vc, 11'd1);
    adv(89);
    chk_cnt("s_v5_hcount", s_hc, 11'd14);
    chk_bit("s_v5_vblnk", s_vb, 1'b0);
    adv(90);
    chk_cnt("s_v6_vcount", s_vc, 11'd6);
    chk_bit("s_v6_vblnk", s_vb, 1'b1);
    chk_bit("s_v6_vsync", s_vs, 1'b0);
    adv(104);
    chk_bit("s_v6end_vsync", s_vs, 1'b0);
    adv(105);
    chk_bit("s_v7_vsync", s_vs, 1'b1);
    chk_bit("n_v7_vsync", n_vs, 1'b0);
    chk_bit("n_v7_vblnk", n_vb, 1'b1);
    adv(134);
    chk_bit("s_v8end_vsync", s_vs, 1'b1);
    adv(135);
    chk_cnt("s_v9_vcount", s_vc, 11'd9);
    chk_bit("s_v9_vsync", s_vs, 1'b0);
    adv(179);
    chk_cnt("s_last_hcount", s_hc, 11'd14);
    chk_cnt("s_last_vcount", s_vc, 11'd11);
    chk_bit("s_last_fs", s_fs, 1'b0);
    adv(180);
    chk_cnt("s_frame_hcount", s_hc, 11'd0);
    chk_cnt("s_frame_vcount", s_vc, 11'd0);
    chk_bit("s_frame_fs", s_fs, 1'b1);
    chk_bit("s_frame_vblnk", s_vb, 1'b0);
    chk_bit("n_frame_fs", n_fs, 1'b1);

    // Pulse spacing across two further frames, each wait bounded.
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      do begin
        tick(1);
        gap++;
        if (gap == 1) chk_bit("fs_one_cycle", s_fs, 1'b0);
      end while (s_fs !== 1'b1 && gap < 1000);
      chk_int("frame_gap", gap, 180);
    end
    chk_bit("big_no_fs", b_fs, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
